alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, registered execute-stage ALU with integrated multiply/divide unit (RV32M/RV64M), sitting in the EX stage between the ID/EX pipeline register and EX/MEM. It computes all base integer, address and branch-compare operations, and executes MUL/DIV/REM variants. Long ops run on a multi-cycle state machine, and the block back-pressures the pipeline through a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, operand/result width (32 or 64)
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from op2

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  operation presented this cycle
- req_ready  out  1  block can accept; high only in IDLE
- flush  in  1  kill any in-flight or presented op
- alu_op1  in  XLEN  operand 1 (signed view; unsigned reinterpretation for *U ops)
- alu_op2  in  XLEN  operand 2 / immediate
- aluop  in  2  00 address add, 01 branch, 10 R-type, 11 I-type arithmetic
- funct3  in  3  operation select
- inst30  in  1  SUB/SRA/SRAI select
- is_m  in  1  funct7==0000001; valid only with aluop=10
- res_valid  out  1  one-cycle pulse, result/branch valid
- alu_result  out  XLEN  registered result
- alu_branch  out  1  registered branch-taken
- busy  out  1  MUL/DIV state active (stall request to hazard unit)

## Operation
- Accept = req_valid & req_ready & !flush. Inputs are captured at accept only.
- Base ops (aluop!=10 or !is_m):
  - 00: op1+op2.
  - 01: result=(op1+op2) with bit0 cleared; branch per funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu, others 0.
  - 10/11: add/sub, sll, slt, sltu, xor, srl/sra, or, and. I-type ignores inst30 except for funct3=101. Shifts use op2[SHAMT_W-1:0].
- M ops (funct3): 000 MUL low, 001 MULH ss, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Divide: restoring, one quotient bit per cycle on magnitudes; quotient sign = sign(op1)^sign(op2); remainder sign = sign(op1).
- Special divide cases resolve without iterating:
  - divisor 0: quotient all-ones, remainder = op1.
  - signed op1=-2^(XLEN-1) with op2=-1: quotient = op1, remainder 0.
- Iterative multiply (macro off): shift-add on magnitudes over 2·XLEN-bit accumulator; sign fixed at end per variant.
- FSM states and transitions:
  - IDLE: base op or fast MUL → DONE; iterative MUL → MUL; DIV normal → DIV; DIV special → DONE.
  - MUL/DIV: count 0..XLEN-1 → DONE.
  - DONE: res_valid=1 → IDLE.
- Reset (any state): IDLE, res_valid 0, alu_result 0, alu_branch 0, busy 0, counter 0. req_ready is 0 while rst is high, 1 the cycle after.

## Timing
- Accept at cycle T.
- Base op: res_valid at T+1.
- Fast MUL: res_valid at T+1.
- Iterative MUL or normal DIV/REM: res_valid at T+1+XLEN (33 cycles at XLEN=32).
- DIV special case: T+1.
- req_ready is low from T+1 until the cycle after res_valid, so back-to-back base ops sustain one per 2 cycles. The pipeline holds ID/EX while busy.
- No output back-pressure: res_valid is a single-cycle pulse. alu_result/alu_branch hold their value until the next res_valid.
- Flush:
  - In MUL/DIV/DONE: IDLE next cycle, no res_valid (DONE pulse suppressed).
  - Same cycle as req_valid: request dropped.
  - Flush wins over accept.
- Reset mid-operation aborts the op with no res_valid.

## Configuration
- ALU_FAST_MUL_EN defined: MUL variants use one combinational 2·XLEN-bit signed/unsigned product, registered into DONE; latency 1.
- Undefined: iterative shift-add in state MUL, latency XLEN+1; no hardware multiplier inferred.
- Divide is always iterative.

## Structure
- Shared header riscv_def.v: ALUOP_* codes, M-extension funct3 codes, FUNCT7_M constant, REG_DATA_WIDTH default for XLEN.
- Sub-module mdu_div_iter: divisor/remainder/quotient registers, counter, start/done, special-case detect; instantiated once.
- The multiply iterator stays in alu_mdu.

## Test plan
- Base ops, XLEN=32: SUB 5−7 → 0xFFFFFFFE at T+1. SRA 0x80000000>>>4 → 0xF8000000. BLTU 1 vs 0xFFFFFFFF → branch 1.
- DIV −7/2 → −3, REM −7/2 → −1, DIVU 0xFFFFFFFF/16 → 0x0FFFFFFF. res_valid at T+33; req_ready low T+1..T+33.
- DIV x/0 → 0xFFFFFFFF, REM 9/0 → 9. DIV 0x80000000/−1 → 0x80000000, REM → 0. All at T+1.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF. Run with and without ALU_FAST_MUL_EN; check latency 1 vs 33.
- Flush at T+10 of a DIV → no res_valid, req_ready high at T+11, next ADD completes normally.
- rst asserted mid-DIV → all outputs 0 next cycle; req_valid during rst ignored.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared ALU/MDU codes and FSM state type.
// Used by alu_mdu and mdu_div_iter.
package alu_mdu_pkg;

  localparam int REG_DATA_WIDTH = 32;

  localparam logic [1:0] ALUOP_ADDR   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider on magnitudes, one quotient bit per cycle.
// Also owns the shared MUL/DIV iteration counter.
module mdu_div_iter
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = REG_DATA_WIDTH,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            run,
  input  logic            step,
  input  logic            kill,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            sgn,
  input  logic            rem_sel,
  output logic            special,
  output logic [XLEN-1:0] special_res,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] quo, rem, dvs;
  logic [XLEN-1:0] quo_nxt, rem_nxt, mag1, mag2;
  logic [XLEN:0]   diff;
  logic            q_neg, r_neg, rsel;
  logic            a_neg, b_neg, div0, ovf;
  logic [CW-1:0]   cnt;

  // Operand magnitudes and early-out cases
  always_comb begin
    a_neg = sgn & op1[XLEN-1];
    b_neg = sgn & op2[XLEN-1];
    mag1  = a_neg ? -op1 : op1;
    mag2  = b_neg ? -op2 : op2;
    div0  = (op2 == '0);
    ovf   = sgn & (op1 == MIN_NEG) & (op2 == '1);
    special = div0 | ovf;
    if (div0) special_res = rem_sel ? op1 : '1;
    else      special_res = rem_sel ? '0 : op1;
  end

  // One restoring step; result taken from the post-step values
  always_comb begin
    diff = {rem, quo[XLEN-1]} - {1'b0, dvs};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = {rem[XLEN-2:0], quo[XLEN-1]};
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
    if (rsel) result = r_neg ? -rem_nxt : rem_nxt;
    else      result = q_neg ? -quo_nxt : quo_nxt;
  end

  // Divider datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rsel  <= 1'b0;
    end else if (start) begin
      quo   <= mag1;
      rem   <= '0;
      dvs   <= mag2;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      rsel  <= rem_sel;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  // Iteration counter, wraps to 0 after the last step
  always_ff @(posedge clk) begin
    if (rst || kill || start) cnt <= '0;
    else if (run)             cnt <= cnt + CW'(1);
  end

  assign last = (cnt == CW'(XLEN-1));

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with RV32M/RV64M multiply/divide.
// ALU_FAST_MUL_EN: single-cycle multiply instead of shift-add.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int XLEN    = REG_DATA_WIDTH,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_op1,
  input  logic [XLEN-1:0] alu_op2,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic            inst30,
  input  logic            is_m,
  output logic            res_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_branch,
  output logic            busy
);

  state_t state, state_nxt;

  logic               accept, is_mop, is_div;
  logic               last, dv_special, a_s, b_s;
  logic [XLEN-1:0]    dv_special_res, dv_result;
  logic [XLEN-1:0]    base_res, mul_res, sum, dif;
  logic [SHAMT_W-1:0] sh;
  logic               base_br, lt, ltu, eq;

  assign req_ready = (state == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready & ~flush;
  assign is_mop    = (aluop == ALUOP_RTYPE) & is_m;
  assign is_div    = is_mop & funct3[2];
  assign res_valid = (state == S_DONE) & ~flush;
  assign busy      = (state == S_MUL) | (state == S_DIV);
  assign a_s       = (funct3 == F3_MULH) | (funct3 == F3_MULHSU);
  assign b_s       = (funct3 == F3_MULH);

  // Base integer, address and branch-compare logic
  always_comb begin
    sh      = alu_op2[SHAMT_W-1:0];
    sum     = alu_op1 + alu_op2;
    dif     = alu_op1 - alu_op2;
    lt      = $signed(alu_op1) < $signed(alu_op2);
    ltu     = alu_op1 < alu_op2;
    eq      = alu_op1 == alu_op2;
    base_res = sum;
    base_br  = 1'b0;
    unique case (aluop)
      ALUOP_ADDR: base_res = sum;
      ALUOP_BRANCH: begin
        base_res = {sum[XLEN-1:1], 1'b0};
        unique case (funct3)
          F3_BEQ:  base_br = eq;
          F3_BNE:  base_br = ~eq;
          F3_BLT:  base_br = lt;
          F3_BGE:  base_br = ~lt;
          F3_BLTU: base_br = ltu;
          F3_BGEU: base_br = ~ltu;
          default: base_br = 1'b0;
        endcase
      end
      default: begin
        unique case (funct3)
          F3_ADD:
            if (aluop == ALUOP_RTYPE && inst30) base_res = dif;
            else                                base_res = sum;
          F3_SLL:  base_res = alu_op1 << sh;
          F3_SLT:  base_res = {{(XLEN-1){1'b0}}, lt};
          F3_SLTU: base_res = {{(XLEN-1){1'b0}}, ltu};
          F3_XOR:  base_res = alu_op1 ^ alu_op2;
          F3_SR:
            if (inst30) base_res = $signed(alu_op1) >>> sh;
            else        base_res = alu_op1 >> sh;
          F3_OR:   base_res = alu_op1 | alu_op2;
          default: base_res = alu_op1 & alu_op2;
        endcase
      end
    endcase
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] ea, eb, prod;

  // Full-width product of sign/zero-extended operands
  always_comb begin
    ea   = {{XLEN{a_s & alu_op1[XLEN-1]}}, alu_op1};
    eb   = {{XLEN{b_s & alu_op2[XLEN-1]}}, alu_op2};
    prod = ea * eb;
    if (funct3 == F3_MUL) mul_res = prod[XLEN-1:0];
    else                  mul_res = prod[2*XLEN-1:XLEN];
  end
`else
  logic [2*XLEN-1:0] acc, mcnd, acc_nxt, fin;
  logic [XLEN-1:0]   mplr, ma, mb;
  logic              m_neg, m_hi;

  // Shift-add step on magnitudes, sign applied at the end
  always_comb begin
    ma      = (a_s & alu_op1[XLEN-1]) ? -alu_op1 : alu_op1;
    mb      = (b_s & alu_op2[XLEN-1]) ? -alu_op2 : alu_op2;
    acc_nxt = mplr[0] ? acc + mcnd : acc;
    fin     = m_neg ? -acc_nxt : acc_nxt;
    if (m_hi) mul_res = fin[2*XLEN-1:XLEN];
    else      mul_res = fin[XLEN-1:0];
  end

  // Multiply iterator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcnd  <= '0;
      mplr  <= '0;
      m_neg <= 1'b0;
      m_hi  <= 1'b0;
    end else if (accept && is_mop && !funct3[2]) begin
      acc   <= '0;
      mcnd  <= {{XLEN{1'b0}}, ma};
      mplr  <= mb;
      m_neg <= (a_s & alu_op1[XLEN-1]) ^ (b_s & alu_op2[XLEN-1]);
      m_hi  <= (funct3 != F3_MUL);
    end else if (state == S_MUL) begin
      acc  <= acc_nxt;
      mcnd <= mcnd << 1;
      mplr <= mplr >> 1;
    end
  end
`endif

  mdu_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (accept & is_mop),
    .run         (busy),
    .step        (state == S_DIV),
    .kill        (flush),
    .op1         (alu_op1),
    .op2         (alu_op2),
    .sgn         (~funct3[0]),
    .rem_sel     (funct3[1]),
    .special     (dv_special),
    .special_res (dv_special_res),
    .last        (last),
    .result      (dv_result)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept) begin
          if (is_div)
            state_nxt = dv_special ? S_DONE : S_DIV;
          else if (is_mop)
`ifdef ALU_FAST_MUL_EN
            state_nxt = S_DONE;
`else
            state_nxt = S_MUL;
`endif
          else
            state_nxt = S_DONE;
        end
      S_MUL, S_DIV:
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result/branch registers, updated only when a result is produced
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      alu_branch <= 1'b0;
    end else if (accept) begin
      if (!is_mop) begin
        alu_result <= base_res;
        alu_branch <= base_br;
      end else if (is_div && dv_special) begin
        alu_result <= dv_special_res;
        alu_branch <= 1'b0;
`ifdef ALU_FAST_MUL_EN
      end else if (!is_div) begin
        alu_result <= mul_res;
        alu_branch <= 1'b0;
`endif
      end
    end else if (!flush && last && state == S_MUL) begin
      alu_result <= mul_res;
      alu_branch <= 1'b0;
    end else if (!flush && last && state == S_DIV) begin
      alu_result <= dv_result;
      alu_branch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (XLEN=32), randomized plus directed.
// Expected latency of multiplies follows ALU_FAST_MUL_EN.
module tb_alu_mdu;

  localparam int XLEN = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] alu_op1 = '0;
  logic [XLEN-1:0] alu_op2 = '0;
  logic [1:0]      aluop = '0;
  logic [2:0]      funct3 = '0;
  logic            inst30 = 1'b0;
  logic            is_m = 1'b0;
  logic            req_ready, res_valid, alu_branch, busy;
  logic [XLEN-1:0] alu_result;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .flush      (flush),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .aluop      (aluop),
    .funct3     (funct3),
    .inst30     (inst30),
    .is_m       (is_m),
    .res_valid  (res_valid),
    .alu_result (alu_result),
    .alu_branch (alu_branch),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        br;
    int          cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   rv_count = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per res_valid pulse
  always @(negedge clk) begin
    #1;
    if (res_valid === 1'b1) begin
      rv_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_res_valid: got result %h, required no pulse",
                 alu_result);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, alu_result, mon_e.res);
        chk({mon_e.name, "_branch"}, alu_branch, mon_e.br);
        chk({mon_e.name, "_latency"}, cyc - mon_e.cyc, mon_e.lat);
      end
    end
  end

  // Reference model from the instruction semantics
  function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                input logic i30, input logic m,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br,
                                output int lat);
    int          ia, ib;
    longint      sa, sb2, ua, ub;
    logic [63:0] p;
    logic [31:0] q, rm;
    ia  = a;
    ib  = b;
    sa  = longint'(ia);
    sb2 = longint'(ib);
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    r   = '0;
    br  = 1'b0;
    lat = 1;
    if (op == 2'b10 && m) begin
      if (!f3[2]) begin
        lat = MUL_LAT;
        case (f3)
          3'd0: p = sa * sb2;
          3'd1: p = sa * sb2;
          3'd2: p = sa * ub;
          default: p = ua * ub;
        endcase
        r = (f3 == 3'd0) ? p[31:0] : p[63:32];
      end else begin
        if (b == 0) begin
          q = '1; rm = a;
        end else if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          q = a; rm = '0;
        end else begin
          lat = DIV_LAT;
          if (!f3[0]) begin q = ia / ib; rm = ia % ib; end
          else        begin q = a / b;   rm = a % b;   end
        end
        r = f3[1] ? rm : q;
      end
    end else if (op == 2'b00) begin
      r = a + b;
    end else if (op == 2'b01) begin
      r = (a + b) & ~32'h1;
      case (f3)
        3'd0: br = (a == b);
        3'd1: br = (a != b);
        3'd4: br = (ia < ib);
        3'd5: br = (ia >= ib);
        3'd6: br = (a < b);
        3'd7: br = (a >= b);
        default: br = 1'b0;
      endcase
    end else begin
      case (f3)
        3'd0: r = (op == 2'b10 && i30) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = {31'h0, ia < ib};
        3'd3: r = {31'h0, a < b};
        3'd4: r = a ^ b;
        3'd5: if (i30) r = ia >>> b[4:0];
              else     r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  // Present one request once ready; track pushes an expectation
  task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                       input logic i30, input logic m,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eb, input int lat,
                       input string name, input bit track);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout: got req_ready=0 required 1", name);
      return;
    end
    aluop = op; funct3 = f3; inst30 = i30; is_m = m;
    alu_op1 = a; alu_op2 = b;
    req_valid = 1'b1;
    if (track) sb.push_back('{er, eb, cyc, lat, name});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue_rand(input logic [1:0] op, input logic [2:0] f3,
                            input logic i30, input logic m,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        br;
    int          lat;
    model(op, f3, i30, m, a, b, r, br, lat);
    issue(op, f3, i30, m, a, b, r, br, lat, "rand", 1'b1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  int rv_before;

  initial begin
    // Reset with a request presented: must be ignored
    req_valid = 1'b1;
    aluop = 2'b00; alu_op1 = 32'd3; alu_op2 = 32'd4;
    repeat (3) @(negedge clk);
    #1;
    chk("ready_in_reset", req_ready, 1'b0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_result", alu_result, 32'h0);
    chk("reset_branch", alu_branch, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_no_res", rv_count, 0);

    // Directed base ops
    issue(2'b10, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1,
          "sub", 1'b1);
    #1;
    chk("sub_ready_low", req_ready, 1'b0);
    issue(2'b10, 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1,
          "sra", 1'b1);
    issue(2'b01, 3'd6, 1'b0, 1'b0, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b1, 1,
          "bltu", 1'b1);

    // Iterative divide with ready/busy window
    issue(2'b10, 3'd4, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0,
          DIV_LAT, "div_m7_2", 1'b1);
    #1;
    chk("div_ready_t1", req_ready, 1'b0);
    chk("div_busy_t1", busy, 1'b1);
    repeat (32) @(negedge clk);
    #1;
    chk("div_ready_t33", req_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("div_ready_t34", req_ready, 1'b1);
    issue(2'b10, 3'd6, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0,
          DIV_LAT, "rem_m7_2", 1'b1);
    issue(2'b10, 3'd5, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 1'b0,
          DIV_LAT, "divu", 1'b1);

    // Divide special cases
    issue(2'b10, 3'd4, 1'b0, 1'b1, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b0, 1,
          "div_by0", 1'b1);
    issue(2'b10, 3'd6, 1'b0, 1'b1, 32'd9, 32'd0, 32'd9, 1'b0, 1,
          "rem_by0", 1'b1);
    issue(2'b10, 3'd4, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
          1'b0, 1, "div_ovf", 1'b1);
    issue(2'b10, 3'd6, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1,
          "rem_ovf", 1'b1);

    // Multiplies
    issue(2'b10, 3'd1, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000,
          1'b0, MUL_LAT, "mulh", 1'b1);
    issue(2'b10, 3'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
          1'b0, MUL_LAT, "mulhsu", 1'b1);
    issue(2'b10, 3'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
          1'b0, MUL_LAT, "mulhu", 1'b1);
    issue(2'b10, 3'd0, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0,
          MUL_LAT, "mul", 1'b1);

    // Flush at T+10 of a divide
    repeat (40) @(negedge clk);
    rv_before = rv_count;
    issue(2'b10, 3'd4, 1'b0, 1'b1, 32'd1000, 32'd3, 32'h0, 1'b0, 0,
          "div_flushed", 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("flush_busy_t5", busy, 1'b1);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_ready_t11", req_ready, 1'b1);
    repeat (40) @(negedge clk);
    chk("flush_no_res", rv_count, rv_before);
    issue(2'b00, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1,
          "add_after_flush", 1'b1);

    // Flush in the same cycle as a request drops it
    repeat (2) @(negedge clk);
    rv_before = rv_count;
    aluop = 2'b00; alu_op1 = 32'd1; alu_op2 = 32'd1;
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_req_ready", req_ready, 1'b1);
    chk("flush_req_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("flush_req_no_res", rv_count, rv_before);

    // Reset in the middle of a divide
    issue(2'b00, 3'd0, 1'b0, 1'b0, 32'd10, 32'd20, 32'd30, 1'b1 & 1'b0, 1,
          "add_pre_rst", 1'b1);
    repeat (2) @(negedge clk);
    rv_before = rv_count;
    issue(2'b10, 3'd5, 1'b0, 1'b1, 32'd1000, 32'd7, 32'h0, 1'b0, 0,
          "div_reset", 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1;
    aluop = 2'b00; is_m = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_result", alu_result, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    repeat (40) @(negedge clk);
    chk("rst_no_res", rv_count, rv_before);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      issue_rand(op, 3'($urandom), 1'($urandom),
                 (op == 2'b10) ? 1'($urandom) : 1'b0, pick(), pick());
    end

    // Drain the scoreboard with a bound
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d outstanding required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
